painterengine_gpu_reader: RTL and testbench

PAINTERENGINE_GPU_READER -- requirements
Module: painterengine_gpu_reader

---
 rtl/painterengine_gpu_reader.sv | 211 +++++++++++++++++++++
 tb/tb_painterengine_gpu_reader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_reader.sv
// AXI4 burst reader: streams a linear run of 32-bit words from memory to a consumer,
// splitting the run into bursts that never cross a 4 KB page, one burst in flight at a time.
module painterengine_gpu_reader #(
  parameter int unsigned C_MAX_BURST = 64
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_reader_resetn,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic [31:0] o_wire_m_axi_araddr,
  output logic [7:0]  o_wire_m_axi_arlen,
  output logic [2:0]  o_wire_m_axi_arsize,
  output logic [1:0]  o_wire_m_axi_arburst,
  output logic        o_wire_m_axi_arvalid,
  input  logic        i_wire_m_axi_arready,
  input  logic [31:0] i_wire_m_axi_rdata,
  input  logic [1:0]  i_wire_m_axi_rresp,
  input  logic        i_wire_m_axi_rlast,
  input  logic        i_wire_m_axi_rvalid,
  output logic        o_wire_m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_ERROR,
    S_DRAIN
  } state_t;

  localparam logic [8:0] MAX_BEATS = C_MAX_BURST[8:0];

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] remaining_q;
  logic [8:0]  beats_q;
  logic [8:0]  beat_cnt_q;
  logic        burst_err_q;
  logic        late_q;
  logic        abort_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic        arvalid_q;
  logic        done_q;
  logic        error_q;

  logic [31:0] page_words_d;
  logic [8:0]  rem_clamp_d;
  logic [8:0]  page_clamp_d;
  logic [8:0]  beats_d;
  logic        rready_d;
  logic        beat_acc_d;
  logic        exp_last_d;
  logic        resp_bad_d;
  logic        flag_now_d;
  logic [31:0] step_bytes_d;
  logic [31:0] remaining_after_d;

  // Words left before the next 4 KB page; addr_q is word aligned so this is exact.
  assign page_words_d = (32'd4096 - {20'd0, addr_q[11:0]}) >> 2;

  always_comb begin
    rem_clamp_d  = (remaining_q > 32'd256) ? 9'd256 : remaining_q[8:0];
    page_clamp_d = (page_words_d > 32'd256) ? 9'd256 : page_words_d[8:0];
    beats_d      = rem_clamp_d;
    if (MAX_BEATS < beats_d) beats_d = MAX_BEATS;
    if (page_clamp_d < beats_d) beats_d = page_clamp_d;
  end

  always_comb begin
    rready_d = 1'b0;
    if (state_q == S_DATA) rready_d = i_wire_data_next;
    else if (state_q == S_DRAIN) rready_d = 1'b1;
  end

  assign beat_acc_d        = i_wire_m_axi_rvalid & rready_d;
  assign exp_last_d        = (beat_cnt_q == beats_q - 9'd1);
  assign resp_bad_d        = (i_wire_m_axi_rresp != 2'b00);
  assign flag_now_d        = burst_err_q | resp_bad_d | (i_wire_m_axi_rlast != exp_last_d);
  assign step_bytes_d      = {21'd0, beats_q, 2'b00};
  assign remaining_after_d = remaining_q - {23'd0, beats_q};

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      remaining_q <= 32'd0;
      beats_q     <= 9'd0;
      beat_cnt_q  <= 9'd0;
      burst_err_q <= 1'b0;
      late_q      <= 1'b0;
      abort_q     <= 1'b0;
      araddr_q    <= 32'd0;
      arlen_q     <= 8'd0;
      arvalid_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_wire_reader_resetn) begin
            addr_q      <= i_wire_address;
            remaining_q <= i_wire_length;
            if (i_wire_address[1:0] != 2'b00) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else if (i_wire_length == 32'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!i_wire_reader_resetn) begin
            state_q <= S_IDLE;
          end else begin
            araddr_q    <= addr_q;
            arlen_q     <= beats_d[7:0] - 8'd1;
            arvalid_q   <= 1'b1;
            beats_q     <= beats_d;
            beat_cnt_q  <= 9'd0;
            burst_err_q <= 1'b0;
            late_q      <= 1'b0;
            abort_q     <= 1'b0;
            state_q     <= S_ADDR;
          end
        end
        S_ADDR: begin
          // An abort cannot retract an offered address; remember it and drain afterwards.
          if (i_wire_m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= (abort_q || !i_wire_reader_resetn) ? S_DRAIN : S_DATA;
          end else if (!i_wire_reader_resetn) begin
            abort_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (!i_wire_reader_resetn) begin
            state_q <= (beat_acc_d && i_wire_m_axi_rlast) ? S_IDLE : S_DRAIN;
          end else if (beat_acc_d) begin
            if (late_q) begin
              if (i_wire_m_axi_rlast) begin
                state_q <= S_ERROR;
                error_q <= 1'b1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 9'd1;
              if (exp_last_d && !i_wire_m_axi_rlast) begin
                // Slave overruns the burst: swallow beats until its rlast shows up.
                late_q      <= 1'b1;
                burst_err_q <= 1'b1;
              end else if (exp_last_d || i_wire_m_axi_rlast) begin
                addr_q      <= addr_q + step_bytes_d;
                remaining_q <= remaining_after_d;
                if (flag_now_d) begin
                  state_q <= S_ERROR;
                  error_q <= 1'b1;
                end else if (remaining_after_d == 32'd0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_CALC;
                end
              end else begin
                burst_err_q <= flag_now_d;
              end
            end
          end
        end
        S_DONE: begin
          if (!i_wire_reader_resetn) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        S_ERROR: begin
          if (!i_wire_reader_resetn) begin
            state_q <= S_IDLE;
            error_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (beat_acc_d && i_wire_m_axi_rlast) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_wire_done          = done_q;
  assign o_wire_error         = error_q;
  assign o_wire_data          = i_wire_m_axi_rdata;
  assign o_wire_data_valid    = beat_acc_d & (state_q == S_DATA) & ~burst_err_q & ~resp_bad_d;
  assign o_wire_m_axi_araddr  = araddr_q;
  assign o_wire_m_axi_arlen   = arlen_q;
  assign o_wire_m_axi_arsize  = 3'b010;
  assign o_wire_m_axi_arburst = 2'b01;
  assign o_wire_m_axi_arvalid = arvalid_q;
  assign o_wire_m_axi_rready  = rready_d;

endmodule

// File: tb/tb_painterengine_gpu_reader.sv
// Bench for painterengine_gpu_reader: behavioural AXI slave plus a page-split/word-list
// reference model, driven by a vector table, random transfers and abort sequences.
module tb_painterengine_gpu_reader;

  localparam int MAXB = 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rn;
  logic [31:0] addr_in, len_in;
  logic        done, error_o, dv, data_next;
  logic [31:0] data_o, araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  painterengine_gpu_reader #(.C_MAX_BURST(MAXB)) dut (
    .i_wire_clock(clk),
    .i_wire_resetn(resetn),
    .i_wire_reader_resetn(rn),
    .i_wire_address(addr_in),
    .i_wire_length(len_in),
    .o_wire_done(done),
    .o_wire_error(error_o),
    .o_wire_data(data_o),
    .o_wire_data_valid(dv),
    .i_wire_data_next(data_next),
    .o_wire_m_axi_araddr(araddr),
    .o_wire_m_axi_arlen(arlen),
    .o_wire_m_axi_arsize(arsize),
    .o_wire_m_axi_arburst(arburst),
    .o_wire_m_axi_arvalid(arvalid),
    .i_wire_m_axi_arready(arready),
    .i_wire_m_axi_rdata(rdata),
    .i_wire_m_axi_rresp(rresp),
    .i_wire_m_axi_rlast(rlast),
    .i_wire_m_axi_rvalid(rvalid),
    .o_wire_m_axi_rready(rready)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } ar_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int dn_p;
    int ar_p;
    int rv_p;
    int err_beat;
    int early_at;
    int late_extra;
    bit exp_done;
    bit exp_err;
    int exp_nar;   // -1: count from model
    int exp_fwd;   // -1: all model words, -2: not checked
  } vec_t;

  ar_t         ar_log[$], pend[$], model_ar[$];
  logic [31:0] got[$], model_w[$];
  int  r_idx, r_nsend, r_burst_no;
  bit  r_have, hs_ar, hs_r;
  logic [31:0] hs_araddr;
  logic [7:0]  hs_arlen;
  int  dn_prob, ar_prob, rv_prob, err_beat, early_at, late_extra;
  bit  draining;
  int  drain_age;
  logic        rn_req;
  logic [31:0] addr_req, len_req;
  int  checks = 0;
  int  errors = 0;

  function automatic logic [31:0] pix(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: settle last edge's handshakes, drive slave/consumer, sample mid-cycle.
  task automatic step();
    @(negedge clk);
    if (hs_ar) begin
      ar_log.push_back('{hs_araddr, hs_arlen});
      pend.push_back('{hs_araddr, hs_arlen});
    end
    if (hs_r && r_have) begin
      r_idx++;
      if (r_idx == r_nsend) begin
        pend.delete(0);
        r_have = 1'b0;
        r_burst_no++;
      end
    end
    if (!r_have && pend.size() > 0) begin
      r_nsend = int'(pend[0].l) + 1;
      if (r_burst_no == 0 && early_at > 0) r_nsend = early_at;
      if (r_burst_no == 0 && late_extra > 0) r_nsend += late_extra;
      r_idx  = 0;
      r_have = 1'b1;
      rvalid = 1'b0;
    end
    arready = (int'($urandom_range(99)) < ar_prob);
    if (r_have) begin
      if (!(rvalid && !hs_r)) rvalid = (int'($urandom_range(99)) < rv_prob);
      rdata = pix(pend[0].a + 32'(4 * r_idx));
      rlast = (r_idx == r_nsend - 1);
      rresp = (r_burst_no == 0 && err_beat > 0 && r_idx + 1 == err_beat) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      rdata  = 32'd0;
    end
    data_next = (int'($urandom_range(99)) < dn_prob);
    rn      = rn_req;
    addr_in = addr_req;
    len_in  = len_req;
    #1;
    hs_ar     = arvalid && arready;
    hs_araddr = araddr;
    hs_arlen  = arlen;
    hs_r      = rvalid && rready;
    if (dv) begin
      check("dv_needs_handshake", {rvalid, rready}, 2'b11);
      if (!draining) got.push_back(data_o);
    end
    if (arvalid) check("one_burst_outstanding", (r_have || pend.size() > 0), 0);
    if (r_have && !draining) check("rready_tracks_data_next", rready, data_next);
    if (draining && drain_age >= 1 && r_have) begin
      check("drain_rready", rready, 1);
      check("drain_no_dv", dv, 0);
    end
    if (draining && drain_age >= 1) check("drain_no_done_err", {done, error_o}, 2'b00);
    if (done || error_o) check("done_err_exclusive", done & error_o, 0);
    if (draining) drain_age++;
  endtask

  task automatic build_model(input logic [31:0] a, input logic [31:0] n);
    logic [31:0] cur, rem, b, pw;
    model_ar.delete();
    model_w.delete();
    for (int i = 0; i < int'(n); i++) model_w.push_back(pix(a + 32'(4 * i)));
    cur = a;
    rem = n;
    while (rem != 0) begin
      pw = (32'd4096 - {20'd0, cur[11:0]}) / 4;
      b = rem;
      if (32'(MAXB) < b) b = 32'(MAXB);
      if (pw < b) b = pw;
      model_ar.push_back('{cur, 8'(b - 1)});
      cur = cur + 4 * b;
      rem = rem - b;
    end
  endtask

  task automatic setup(input vec_t v);
    dn_prob = v.dn_p; ar_prob = v.ar_p; rv_prob = v.rv_p;
    err_beat = v.err_beat; early_at = v.early_at; late_extra = v.late_extra;
    build_model(v.addr, v.len);
    ar_log.delete();
    got.delete();
    r_burst_no = 0;
    draining = 1'b0;
    drain_age = 0;
    addr_req = v.addr;
    len_req  = v.len;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, nar, nw;
    bit fin;
    setup(v);
    rn_req = 1'b1;
    lat = 0;
    fin = 1'b0;
    while (lat < 20000 && !fin) begin
      step();
      lat++;
      fin = done || error_o;
    end
    check("transfer_finished", fin, 1);
    if (v.len == 0 || v.addr[1:0] != 2'b00) check("no_ar_latency", lat, 2);
    check("done", done, v.exp_done);
    check("error", error_o, v.exp_err);
    step();
    step();
    check("done_err_held", {done, error_o}, {v.exp_done, v.exp_err});
    nar = (v.exp_nar < 0) ? model_ar.size() : v.exp_nar;
    check("burst_count", ar_log.size(), nar);
    for (int i = 0; i < ar_log.size() && i < model_ar.size(); i++) begin
      check("burst_addr", ar_log[i].a, model_ar[i].a);
      check("burst_len", ar_log[i].l, model_ar[i].l);
    end
    if (v.exp_fwd != -2) begin
      nw = (v.exp_fwd < 0) ? model_w.size() : v.exp_fwd;
      check("word_count", got.size(), nw);
      for (int i = 0; i < got.size() && i < model_w.size(); i++) begin
        int e0;
        e0 = errors;
        check("word_data", got[i], model_w[i]);
        if (errors != e0) break;
      end
    end
    check("slave_idle", pend.size(), 0);
    rn_req = 1'b0;
    step();
    check("status_until_drop", {done, error_o}, {v.exp_done, v.exp_err});
    step();
    check("status_cleared", {done, error_o}, 2'b00);
    $display("xfer %s addr=%08h len=%0d done=%0b error=%0b bursts=%0d words=%0d cycles=%0d",
             tag, v.addr, v.len, v.exp_done, v.exp_err, ar_log.size(), got.size(), lat);
  endtask

  vec_t vecs[11];
  vec_t rv;

  initial begin
    int n;
    logic [31:0] tmp;
    vecs[0]  = '{32'h1000_0000, 128, 100, 100, 100, 0, 0, 0, 1, 0, -1, -1};
    vecs[1]  = '{32'h0000_0FF0,  10, 100, 100, 100, 0, 0, 0, 1, 0, -1, -1};
    vecs[2]  = '{32'h2000_0000,  32,  50,  70,  80, 0, 0, 0, 1, 0, -1, -1};
    vecs[3]  = '{32'h3000_0000,  16, 100, 100, 100, 5, 0, 0, 0, 1,  1,  4};
    vecs[4]  = '{32'h7000_0000,   0, 100, 100, 100, 0, 0, 0, 1, 0,  0,  0};
    vecs[5]  = '{32'h1000_0002,   4, 100, 100, 100, 0, 0, 0, 0, 1,  0,  0};
    vecs[6]  = '{32'h4000_0000,   8, 100, 100, 100, 0, 3, 0, 0, 1,  1, -2};
    vecs[7]  = '{32'h4000_1000,   8,  80, 100, 100, 0, 0, 2, 0, 1,  1, -2};
    vecs[8]  = '{32'hFFFF_FFF0,   8, 100, 100, 100, 0, 0, 0, 1, 0, -1, -1};
    vecs[9]  = '{32'h0000_0FFC, 300,  70,  50,  60, 0, 0, 0, 1, 0, -1, -1};
    vecs[10] = '{32'h8000_0000,  16,  60,  60,  70, 5, 0, 0, 0, 1,  1,  4};

    resetn = 1'b0; rn_req = 1'b0; addr_req = 0; len_req = 0;
    rn = 1'b0; addr_in = 0; len_in = 0; data_next = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 0; rdata = 0;
    hs_ar = 0; hs_r = 0; r_have = 0; r_idx = 0; r_nsend = 0; r_burst_no = 0;
    dn_prob = 100; ar_prob = 100; rv_prob = 100; err_beat = 0; early_at = 0; late_extra = 0;
    draining = 0; drain_age = 0;

    step();
    step();
    check("rst_done_error", {done, error_o}, 2'b00);
    check("rst_valids", {dv, arvalid, rready}, 3'b000);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_arsize_arburst", {arsize, arburst}, 5'b010_01);
    @(negedge clk);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        check("basic_b0_addr", ar_log[0].a, 32'h1000_0000);
        check("basic_b0_len", ar_log[0].l, 63);
        check("basic_b1_addr", ar_log[1].a, 32'h1000_0100);
        check("basic_b1_len", ar_log[1].l, 63);
      end
      if (i == 1) begin
        check("split_b0", {ar_log[0].a, ar_log[0].l}, {32'h0000_0FF0, 8'd3});
        check("split_b1", {ar_log[1].a, ar_log[1].l}, {32'h0000_1000, 8'd5});
      end
    end

    // Abort in the middle of a data burst: the tail is drained silently.
    setup('{32'h5000_0000, 32, 60, 100, 80, 0, 0, 0, 0, 0, -1, -1});
    rn_req = 1'b1;
    n = 0;
    while (got.size() < 5 && n < 2000) begin step(); n++; end
    check("abort_reached_data", got.size() >= 5, 1);
    rn_req = 1'b0;
    draining = 1'b1;
    drain_age = 0;
    step();
    n = 0;
    while ((r_have || pend.size() > 0) && n < 2000) begin step(); n++; end
    check("abort_drained", (r_have || pend.size() > 0), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_idle_quiet", {arvalid, done, error_o}, 3'b000);
    end
    for (int i = 0; i < got.size(); i++) check("abort_prefix", got[i], model_w[i]);
    $display("xfer abort_data words_before_abort=%0d", got.size());
    draining = 1'b0;

    // Abort while the address is offered: arvalid must stay until accepted.
    setup('{32'h6000_0000, 8, 100, 0, 100, 0, 0, 0, 0, 0, -1, -1});
    rn_req = 1'b1;
    n = 0;
    while (!arvalid && n < 50) begin step(); n++; end
    check("addr_abort_arvalid_seen", arvalid, 1);
    rn_req = 1'b0;
    draining = 1'b1;
    drain_age = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("addr_abort_arvalid_held", {arvalid, araddr}, {1'b1, 32'h6000_0000});
    end
    ar_prob = 100;
    n = 0;
    while ((ar_log.size() == 0 || r_have || pend.size() > 0) && n < 500) begin step(); n++; end
    check("addr_abort_drained", (ar_log.size() == 1 && !r_have && pend.size() == 0), 1);
    step();
    check("addr_abort_idle", {arvalid, done, error_o, rready}, 4'b0000);
    $display("xfer abort_addr bursts=%0d", ar_log.size());
    draining = 1'b0;
    run_vec('{32'h0000_2000, 4, 100, 100, 100, 0, 0, 0, 1, 0, -1, -1}, "after_abort");

    // Random transfers, biased towards page boundaries.
    for (int k = 0; k < 20; k++) begin
      tmp = $urandom();
      tmp[1:0] = 2'b00;
      if ($urandom_range(1) == 1) tmp[11:0] = 12'(4096 - 4 * int'($urandom_range(40, 1)));
      rv = '{tmp, 32'($urandom_range(300)), int'($urandom_range(100, 30)),
             int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
             0, 0, 0, 1, 0, -1, -1};
      run_vec(rv, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
